mult_div: RTL

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mult_div.sv
// mult_div: multi-cycle signed 32x32 multiplier / divider.
// MULT uses radix-2 Booth on a 64-bit accumulator. DIV uses restoring
// division on operand magnitudes, followed by a one-cycle sign fix-up.
// Sequence is IDLE -> RUN (32 cycles) -> FIX -> DONE, so Done rises in the
// 34th cycle after the Start sampling edge.
// Optional macro MULT_DIV_FAST_ZERO_EN: a MULT with a zero operand skips RUN
// and goes through FIX with a zero accumulator, so Done rises 2 cycles after
// the Start edge.
module mult_div (
   input  logic        Clk,
   input  logic        Reset_N,
   input  logic        Start,
   input  logic        Op,
   input  logic [31:0] Src_A,
   input  logic [31:0] Src_B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        Done,
   output logic        Div_Zero
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state;
   logic        op_r;      // latched operation: 0 = MULT, 1 = DIV
   logic [4:0]  count;     // iteration counter, 31 down to 0
   logic [32:0] acc_hi;    // MULT: upper product (sign-extended); DIV: remainder
   logic [31:0] acc_lo;    // MULT: multiplier / lower product; DIV: dividend / quotient
   logic        q_m1;      // Booth bit to the right of the multiplier LSB
   logic [31:0] mcand;     // MULT: multiplicand; DIV: divisor magnitude
   logic        neg_q;     // quotient must be negated
   logic        neg_r;     // remainder must be negated

   logic [32:0] booth_hi;
   logic [32:0] div_shift;
   logic [33:0] div_diff;
   logic [32:0] nxt_hi;
   logic [31:0] nxt_lo;
   logic        nxt_qm1;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        fast_zero;

   assign mag_a = Src_A[31] ? (32'd0 - Src_A) : Src_A;
   assign mag_b = Src_B[31] ? (32'd0 - Src_B) : Src_B;

`ifdef MULT_DIV_FAST_ZERO_EN
   assign fast_zero = ~Op & ((Src_A == 32'd0) | (Src_B == 32'd0));
`else
   assign fast_zero = 1'b0;
`endif

   // One Booth step or one restoring-division step on the current accumulator.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      booth_hi  = acc_hi;
      div_shift = {acc_hi[31:0], acc_lo[31]};
      div_diff  = {1'b0, div_shift} - {2'b00, mcand};
      nxt_hi    = acc_hi;
      nxt_lo    = acc_lo;
      nxt_qm1   = q_m1;
      if (!op_r) begin
         case ({acc_lo[0], q_m1})
            2'b01:   booth_hi = acc_hi + {mcand[31], mcand};
            2'b10:   booth_hi = acc_hi - {mcand[31], mcand};
            default: booth_hi = acc_hi;
         endcase
         nxt_hi  = {booth_hi[32], booth_hi[32:1]};
         nxt_lo  = {booth_hi[0], acc_lo[31:1]};
         nxt_qm1 = acc_lo[0];
      end else if (!div_diff[33]) begin
         nxt_hi = div_diff[32:0];
         nxt_lo = {acc_lo[30:0], 1'b1};
      end else begin
         nxt_hi = div_shift;
         nxt_lo = {acc_lo[30:0], 1'b0};
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge Clk or negedge Reset_N) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values; blocking assignments belong in always_comb.
      if (!Reset_N) begin
         state    <= IDLE;
         op_r     <= 1'b0;
         count    <= 5'd0;
         acc_hi   <= 33'd0;
         acc_lo   <= 32'd0;
         q_m1     <= 1'b0;
         mcand    <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         HI       <= 32'd0;
         LO       <= 32'd0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Div_Zero <= 1'b0;
      end else begin
         Done     <= 1'b0;
         Div_Zero <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  if (Op && (Src_B == 32'd0)) begin
                     Div_Zero <= 1'b1;
                  end else if (fast_zero) begin
                     op_r   <= 1'b0;
                     count  <= 5'd31;
                     acc_hi <= 33'd0;
                     acc_lo <= 32'd0;
                     Busy   <= 1'b1;
                     state  <= FIX;
                  end else begin
                     op_r   <= Op;
                     count  <= 5'd31;
                     acc_hi <= 33'd0;
                     q_m1   <= 1'b0;
                     Busy   <= 1'b1;
                     state  <= RUN;
                     if (Op) begin
                        acc_lo <= mag_a;
                        mcand  <= mag_b;
                        neg_q  <= Src_A[31] ^ Src_B[31];
                        neg_r  <= Src_A[31];
                     end else begin
                        acc_lo <= Src_B;
                        mcand  <= Src_A;
                     end
                  end
               end
            end
            RUN: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               q_m1   <= nxt_qm1;
               if (count == 5'd0) begin
                  state <= FIX;
               end else begin
                  count <= count - 5'd1;
               end
            end
            FIX: begin
               if (op_r) begin
                  LO <= neg_q ? (32'd0 - acc_lo) : acc_lo;
                  HI <= neg_r ? (32'd0 - acc_hi[31:0]) : acc_hi[31:0];
               end else begin
                  LO <= acc_lo;
                  HI <= acc_hi[31:0];
               end
               Done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
